// File: rtl/morse_pkg.sv
// Shared Morse definitions: character codes, FSM state encoding and the ITU pattern table.
package morse_pkg;

   localparam int unsigned CNT_W = 19;

   localparam logic [5:0] CODE_LAST_DIGIT = 6'd35;
   localparam logic [5:0] CODE_WORD_SPACE = 6'd36;

   localparam logic [2:0] UNITS_DOT  = 3'd1;
   localparam logic [2:0] UNITS_DASH = 3'd3;
   localparam logic [2:0] UNITS_WORD = 3'd7;

   typedef enum logic [2:0] {
      IDLE,
      MARK,
      ELEM_GAP,
      CHAR_GAP,
      WORD_GAP,
      ERR_ACK
   } state_t;

   // bits[0] is the first element sent; 1 = dash
   typedef struct packed {
      logic [2:0] len;
      logic [4:0] bits;
   } pattern_t;

   function automatic pattern_t pattern_lookup(input logic [5:0] code);
      pattern_t p;
      case (code)
         6'd0:  p = '{3'd2, 5'b00010}; // A
         6'd1:  p = '{3'd4, 5'b00001}; // B
         6'd2:  p = '{3'd4, 5'b00101}; // C
         6'd3:  p = '{3'd3, 5'b00001}; // D
         6'd4:  p = '{3'd1, 5'b00000}; // E
         6'd5:  p = '{3'd4, 5'b00100}; // F
         6'd6:  p = '{3'd3, 5'b00011}; // G
         6'd7:  p = '{3'd4, 5'b00000}; // H
         6'd8:  p = '{3'd2, 5'b00000}; // I
         6'd9:  p = '{3'd4, 5'b01110}; // J
         6'd10: p = '{3'd3, 5'b00101}; // K
         6'd11: p = '{3'd4, 5'b00010}; // L
         6'd12: p = '{3'd2, 5'b00011}; // M
         6'd13: p = '{3'd2, 5'b00001}; // N
         6'd14: p = '{3'd3, 5'b00111}; // O
         6'd15: p = '{3'd4, 5'b00110}; // P
         6'd16: p = '{3'd4, 5'b01011}; // Q
         6'd17: p = '{3'd3, 5'b00010}; // R
         6'd18: p = '{3'd3, 5'b00000}; // S
         6'd19: p = '{3'd1, 5'b00001}; // T
         6'd20: p = '{3'd3, 5'b00100}; // U
         6'd21: p = '{3'd4, 5'b01000}; // V
         6'd22: p = '{3'd3, 5'b00110}; // W
         6'd23: p = '{3'd4, 5'b01001}; // X
         6'd24: p = '{3'd4, 5'b01101}; // Y
         6'd25: p = '{3'd4, 5'b00011}; // Z
         6'd26: p = '{3'd5, 5'b11111}; // 0
         6'd27: p = '{3'd5, 5'b11110}; // 1
         6'd28: p = '{3'd5, 5'b11100}; // 2
         6'd29: p = '{3'd5, 5'b11000}; // 3
         6'd30: p = '{3'd5, 5'b10000}; // 4
         6'd31: p = '{3'd5, 5'b00000}; // 5
         6'd32: p = '{3'd5, 5'b00001}; // 6
         6'd33: p = '{3'd5, 5'b00011}; // 7
         6'd34: p = '{3'd5, 5'b00111}; // 8
         6'd35: p = '{3'd5, 5'b01111}; // 9
         default: p = '{3'd0, 5'b00000};
      endcase
      return p;
   endfunction

endpackage

// File: rtl/morse_tx_ctrl_if.sv
// Character request handshake and key/status outputs of the Morse transmitter.
interface morse_tx_ctrl_if;
   logic        char_valid;
   logic [5:0]  char_code;
   logic        char_ready;
   logic [15:0] unit_div;
   logic        key;
   logic        busy;
   logic        err;

   modport master (
      output char_valid, char_code, unit_div,
      input  char_ready, key, busy, err
   );

   modport slave (
      input  char_valid, char_code, unit_div,
      output char_ready, key, busy, err
   );
endinterface

// File: rtl/morse_unit_timer.sv
// Duration countdown: a load starts a span of units*d cycles; done is high in its last cycle.
module morse_unit_timer
   import morse_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic [15:0] d,
   input  logic [2:0]  units,
   output logic        done
);

   logic [CNT_W-1:0] cnt;

   // 7 * 65535 fits in 19 bits, so the product never wraps
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= CNT_W'(units) * CNT_W'(d) - CNT_W'(1);
      end else if (cnt != '0) begin
         cnt <= cnt - CNT_W'(1);
      end
   end

   assign done = (cnt == '0);

endmodule

// File: rtl/morse_tx_ctrl.sv
// Morse character transmitter: accepts one code at a time and keys its dot/dash pattern
// with ITU element, character and word spacing.
module morse_tx_ctrl
   import morse_pkg::*;
(
   input logic            CLK,
   input logic            Reset,
   morse_tx_ctrl_if.slave bus
);

   state_t      state, next_state;
   pattern_t    pat, code_pat;
   logic [15:0] d_reg, d_cur;
   logic [2:0]  idx;
   logic [2:0]  units;
   logic        accept, invalid, load, done;

   assign code_pat = pattern_lookup(bus.char_code);
   assign accept   = (state == IDLE) && bus.char_valid;
   assign invalid  = (bus.char_code > CODE_WORD_SPACE);

   // The timer is loaded on the accepting edge, before d_reg holds the captured unit
   assign d_cur = (state == IDLE) ? ((bus.unit_div == 16'd0) ? 16'd1 : bus.unit_div) : d_reg;

   morse_unit_timer u_timer (
      .clk   (CLK),
      .rst   (Reset),
      .load  (load),
      .d     (d_cur),
      .units (units),
      .done  (done)
   );

   always_comb begin
      next_state = state;
      load       = 1'b0;
      units      = UNITS_DOT;
      case (state)
         IDLE: begin
            if (bus.char_valid) begin
               if (bus.char_code <= CODE_LAST_DIGIT) begin
                  next_state = MARK;
                  load       = 1'b1;
                  units      = code_pat.bits[0] ? UNITS_DASH : UNITS_DOT;
               end else if (bus.char_code == CODE_WORD_SPACE) begin
                  next_state = WORD_GAP;
                  load       = 1'b1;
                  units      = UNITS_WORD;
               end else begin
                  next_state = ERR_ACK;
               end
            end
         end
         MARK: begin
            if (done) begin
               load = 1'b1;
               if (idx == pat.len - 3'd1) begin
                  next_state = CHAR_GAP;
                  units      = UNITS_DASH;
               end else begin
                  next_state = ELEM_GAP;
                  units      = UNITS_DOT;
               end
            end
         end
         ELEM_GAP: begin
            if (done) begin
               next_state = MARK;
               load       = 1'b1;
               units      = pat.bits[idx] ? UNITS_DASH : UNITS_DOT;
            end
         end
         CHAR_GAP, WORD_GAP: begin
            if (done) next_state = IDLE;
         end
         ERR_ACK: next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (Reset) begin
         state   <= IDLE;
         idx     <= 3'd0;
         bus.key <= 1'b0;
         bus.err <= 1'b0;
      end else begin
         state   <= next_state;
         bus.key <= (next_state == MARK);
         if (accept && invalid) bus.err <= 1'b1;
         // idx advances on leaving a mark so ELEM_GAP already points at the next element
         if (accept) begin
            idx <= 3'd0;
         end else if (state == MARK && next_state == ELEM_GAP) begin
            idx <= idx + 3'd1;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (accept) begin
         d_reg <= d_cur;
         pat   <= code_pat;
      end
   end

   assign bus.char_ready = (state == IDLE) && !Reset;
   assign bus.busy       = (state != IDLE);

endmodule

// File: tb/tb_morse_tx_ctrl.sv
// Directed bench for morse_tx_ctrl; inputs change and outputs are sampled on the falling edge.
module tb_morse_tx_ctrl;
   logic CLK;
   logic Reset;
   int   checks;
   int   failures;

   morse_tx_ctrl_if bus();

   morse_tx_ctrl dut (
      .CLK   (CLK),
      .Reset (Reset),
      .bus   (bus)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic test_reset();
      Reset = 1'b1;
      bus.char_valid = 1'b0;
      bus.char_code  = 6'd0;
      bus.unit_div   = 16'd1;
      @(negedge CLK);
      @(negedge CLK);
      checks++;
      if (bus.char_ready !== 1'b0 || bus.key !== 1'b0 || bus.busy !== 1'b0 || bus.err !== 1'b0) begin
         failures++;
         $display("FAIL reset_hold ready/key/busy/err got=%b%b%b%b exp=0000",
                  bus.char_ready, bus.key, bus.busy, bus.err);
      end
      Reset = 1'b0;
      @(negedge CLK);
      checks++;
      if (bus.char_ready !== 1'b1 || bus.busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_release ready/busy got=%b%b exp=10", bus.char_ready, bus.busy);
      end
   endtask

   // E with D=2; valid/code toggled while busy must be ignored
   task automatic test_letter_e();
      logic exp_key, exp_ready;
      bus.unit_div = 16'd2; bus.char_code = 6'd4; bus.char_valid = 1'b1;
      @(negedge CLK);
      bus.char_valid = 1'b0;
      for (int k = 0; k < 10; k++) begin
         exp_key   = (k < 2);
         exp_ready = (k >= 8);
         checks++;
         if (bus.key !== exp_key) begin
            failures++;
            $display("FAIL e_key k=%0d got=%b exp=%b", k, bus.key, exp_key);
         end
         checks++;
         if (bus.char_ready !== exp_ready || bus.busy !== !exp_ready) begin
            failures++;
            $display("FAIL e_ready k=%0d ready/busy got=%b%b exp=%b%b", k, bus.char_ready, bus.busy,
                     exp_ready, !exp_ready);
         end
         if (k == 3) begin bus.char_valid = 1'b1; bus.char_code = 6'd36; end
         if (k == 5) bus.char_valid = 1'b0;
         @(negedge CLK);
      end
   endtask

   // A with D=2; unit_div changed mid-character must not alter timing
   task automatic test_letter_a();
      logic exp_key, exp_ready;
      bus.unit_div = 16'd2; bus.char_code = 6'd0; bus.char_valid = 1'b1;
      @(negedge CLK);
      bus.char_valid = 1'b0;
      bus.unit_div = 16'd5;
      for (int k = 0; k < 18; k++) begin
         exp_key   = (k < 2) || (k >= 4 && k < 10);
         exp_ready = (k >= 16);
         checks++;
         if (bus.key !== exp_key || bus.char_ready !== exp_ready) begin
            failures++;
            $display("FAIL a_seq k=%0d key/ready got=%b%b exp=%b%b", k, bus.key, bus.char_ready,
                     exp_key, exp_ready);
         end
         @(negedge CLK);
      end
   endtask

   task automatic test_word_space();
      logic exp_busy;
      bus.unit_div = 16'd0; bus.char_code = 6'd36; bus.char_valid = 1'b1;
      @(negedge CLK);
      bus.char_valid = 1'b0;
      for (int k = 0; k < 9; k++) begin
         exp_busy = (k < 7);
         checks++;
         if (bus.busy !== exp_busy || bus.key !== 1'b0 || bus.err !== 1'b0 ||
             bus.char_ready !== !exp_busy) begin
            failures++;
            $display("FAIL word k=%0d busy/key/err/ready got=%b%b%b%b exp=%b00%b", k, bus.busy,
                     bus.key, bus.err, bus.char_ready, exp_busy, !exp_busy);
         end
         @(negedge CLK);
      end
   endtask

   task automatic test_invalid();
      bus.unit_div = 16'd3; bus.char_code = 6'd40; bus.char_valid = 1'b1;
      @(negedge CLK);
      bus.char_valid = 1'b0;
      checks++;
      if (bus.err !== 1'b1 || bus.key !== 1'b0 || bus.busy !== 1'b1 || bus.char_ready !== 1'b0) begin
         failures++;
         $display("FAIL inv_ack err/key/busy/ready got=%b%b%b%b exp=1010", bus.err, bus.key,
                  bus.busy, bus.char_ready);
      end
      @(negedge CLK);
      checks++;
      if (bus.err !== 1'b1 || bus.busy !== 1'b0 || bus.char_ready !== 1'b1) begin
         failures++;
         $display("FAIL inv_done err/busy/ready got=%b%b%b exp=101", bus.err, bus.busy,
                  bus.char_ready);
      end
   endtask

   // T then E, valid held high, D=1: E is taken on the single idle cycle after T
   task automatic test_back_to_back();
      logic exp_key, exp_busy, exp_ready;
      bus.unit_div = 16'd1; bus.char_code = 6'd19; bus.char_valid = 1'b1;
      @(negedge CLK);
      bus.char_code = 6'd4;
      for (int k = 0; k < 12; k++) begin
         exp_key   = (k <= 2) || (k == 7);
         exp_busy  = (k != 6) && (k <= 10);
         exp_ready = (k == 6) || (k == 11);
         checks++;
         if (bus.key !== exp_key || bus.busy !== exp_busy || bus.char_ready !== exp_ready) begin
            failures++;
            $display("FAIL b2b k=%0d key/busy/ready got=%b%b%b exp=%b%b%b", k, bus.key, bus.busy,
                     bus.char_ready, exp_key, exp_busy, exp_ready);
         end
         if (k == 10) bus.char_valid = 1'b0;
         @(negedge CLK);
      end
      checks++;
      if (bus.err !== 1'b1) begin
         failures++;
         $display("FAIL err_sticky got=%b exp=1", bus.err);
      end
   endtask

   task automatic test_reset_mid_mark();
      logic exp_key, exp_ready;
      bus.unit_div = 16'd2; bus.char_code = 6'd19; bus.char_valid = 1'b1;
      @(negedge CLK);
      bus.char_valid = 1'b0;
      @(negedge CLK);
      checks++;
      if (bus.key !== 1'b1) begin
         failures++;
         $display("FAIL rst_pre_key got=%b exp=1", bus.key);
      end
      Reset = 1'b1;
      @(negedge CLK);
      checks++;
      if (bus.key !== 1'b0 || bus.busy !== 1'b0 || bus.err !== 1'b0 || bus.char_ready !== 1'b0) begin
         failures++;
         $display("FAIL rst_mid key/busy/err/ready got=%b%b%b%b exp=0000", bus.key, bus.busy,
                  bus.err, bus.char_ready);
      end
      Reset = 1'b0;
      @(negedge CLK);
      checks++;
      if (bus.key !== 1'b0 || bus.char_ready !== 1'b1) begin
         failures++;
         $display("FAIL rst_after key/ready got=%b%b exp=01", bus.key, bus.char_ready);
      end
      bus.char_code = 6'd4; bus.char_valid = 1'b1;
      @(negedge CLK);
      bus.char_valid = 1'b0;
      for (int k = 0; k < 10; k++) begin
         exp_key   = (k < 2);
         exp_ready = (k >= 8);
         checks++;
         if (bus.key !== exp_key || bus.char_ready !== exp_ready) begin
            failures++;
            $display("FAIL rst_e k=%0d key/ready got=%b%b exp=%b%b", k, bus.key, bus.char_ready,
                     exp_key, exp_ready);
         end
         @(negedge CLK);
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      test_reset();
      test_letter_e();
      test_letter_a();
      test_word_space();
      test_invalid();
      test_back_to_back();
      test_reset_mid_mark();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
